fifo_256x32_byte_drain: RTL and testbench

//  Read-side consumer for the 256x32 synchronous FIFO. Pops 32-bit words once the FIFO reports ready.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_256x32_byte_drain.sv | 95 +++++++++
 tb/tb_fifo_256x32_byte_drain.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and sizing constants for the 256x32 FIFO and its consumers.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    LATCH,
    SEND
  } drain_state_t;

  localparam int unsigned FIFO_DW        = 32;
  localparam int unsigned FIFO_CW        = 8;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/fifo_256x32_byte_drain.sv
// Burst-gated FIFO drain: pops 32-bit words and serialises them LSB-first
// onto a valid/ready byte stream.
module fifo_256x32_byte_drain
  import fifo_pkg::*;
#(
  parameter int unsigned BURST_MIN = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               fifo_rdy,
  input  logic               fifo_empty,
  input  logic               fifo_full,
  input  logic [FIFO_CW-1:0] fifo_dcnt,
  input  logic [FIFO_DW-1:0] fifo_dout,
  output logic               fifo_rd_en,
  input  logic               flush,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [7:0]         tx_data,
  output logic               busy,
  output logic [CNT_W-1:0]   word_cnt
);

  localparam logic [FIFO_CW-1:0] BurstMin = FIFO_CW'(BURST_MIN);
  localparam logic [1:0]         LastByte = 2'(BYTES_PER_WORD - 1);

  drain_state_t       state_q, state_d;
  logic               in_burst_q;
  logic [FIFO_DW-1:0] shift_q;
  logic [1:0]         byte_idx_q;
  logic [CNT_W-1:0]   word_cnt_q;
  logic               go;
  logic               accept;

  // fifo_full must override the count: dcnt wraps to 0 at 256 words.
  assign go = fifo_rdy & ~fifo_empty &
              (in_burst_q | flush | fifo_full | (fifo_dcnt >= BurstMin));
  assign accept = (state_q == SEND) & tx_ready;

  always_comb begin
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = '0;
    case (state_q)
      IDLE: begin
        if (go) state_d = POP;
      end
      POP: begin
        if (fifo_rdy && !fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = LATCH;
        end else begin
          state_d = IDLE;
        end
      end
      LATCH: state_d = SEND;
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = shift_q[7:0];
        if (tx_ready && byte_idx_q == LastByte) begin
          state_d = (!fifo_empty && fifo_rdy) ? POP : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      in_burst_q <= 1'b0;
      shift_q    <= '0;
      byte_idx_q <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == POP) in_burst_q <= 1'b1;
      if (state_q == SEND && state_d == IDLE) in_burst_q <= 1'b0;
      if (state_q == LATCH) begin
        shift_q    <= fifo_dout;
        byte_idx_q <= '0;
      end else if (accept) begin
        shift_q    <= shift_q >> 8;
        byte_idx_q <= byte_idx_q + 2'd1;
        if (byte_idx_q == LastByte) word_cnt_q <= word_cnt_q + 1'b1;
      end
    end
  end

  assign busy     = (state_q != IDLE);
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_fifo_256x32_byte_drain.sv
// Directed/randomised bench for fifo_256x32_byte_drain with a behavioural FIFO
// and a byte-queue reference model.
module tb_fifo_256x32_byte_drain;

  localparam int unsigned CNT_W = 4;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        fifo_rdy = 1'b0;
  logic        fifo_empty, fifo_full;
  logic [7:0]  fifo_dcnt;
  logic [31:0] fifo_dout = '0;
  logic        fifo_rd_en;
  logic        flush = 1'b0;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        busy;
  logic [CNT_W-1:0] word_cnt;

  fifo_256x32_byte_drain #(
    .BURST_MIN(16),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .fifo_rdy  (fifo_rdy),
    .fifo_empty(fifo_empty),
    .fifo_full (fifo_full),
    .fifo_dcnt (fifo_dcnt),
    .fifo_dout (fifo_dout),
    .fifo_rd_en(fifo_rd_en),
    .flush     (flush),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .busy      (busy),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural 256x32 FIFO; not reset by nrst so contents survive a drain reset.
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] mem [256];
  logic [7:0]  wp = '0, rp = '0;
  int          fcnt = 0;

  always @(posedge clk) begin
    if (wr_en && fcnt < 256) begin
      mem[wp] <= wr_data;
      wp      <= wp + 8'd1;
    end
    if (fifo_rd_en && fcnt > 0) begin
      fifo_dout <= mem[rp];
      rp        <= rp + 8'd1;
    end
    fcnt <= fcnt + ((wr_en && fcnt < 256) ? 1 : 0) - ((fifo_rd_en && fcnt > 0) ? 1 : 0);
  end

  assign fifo_empty = (fcnt == 0);
  assign fifo_full  = (fcnt == 256);
  assign fifo_dcnt  = 8'(fcnt);

  // Reference model: bytes still owed to the sink, in order.
  logic [7:0] exp_q [$];
  logic [7:0] cap_q [$];
  int checks = 0, errors = 0;
  int acc = 0, pops = 0;
  bit rand_ready = 1'b0;
  bit ready_fixed = 1'b1;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tx_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
    @(negedge clk);
    if (nrst) begin
      if (prev_stall) begin
        chk("hold_valid", 32'(tx_valid), 32'd1);
        chk("hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (fifo_rd_en) begin
        pops++;
        chk("pop_legal", {30'd0, fifo_rdy, fifo_empty}, 32'd2);
      end
      chk("word_cnt", 32'(word_cnt), 32'((acc / 4) % (1 << CNT_W)));
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) chk("extra_byte", 32'(exp_q.size()), 32'd1);
        else chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
        cap_q.push_back(tx_data);
        acc++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    step();
    wr_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 8000) begin
      step();
      n++;
    end
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int a0, p0, lat, n;

    // Reset state
    #2;
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_cnt", 32'(word_cnt), 32'd0);
    repeat (3) step();
    nrst = 1'b1;
    fifo_rdy = 1'b1;

    // 1: threshold gating
    rand_ready = 1'b1;
    a0 = acc;
    p0 = pops;
    for (int i = 0; i < 15; i++) push_word($urandom);
    repeat (20) step();
    chk("t1_no_pop", 32'(pops - p0), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    push_word($urandom);
    drain("t1");
    chk("t1_bytes", 32'(acc - a0), 32'd64);
    chk("t1_pops", 32'(pops - p0), 32'd16);
    chk("t1_empty", 32'(fifo_empty), 32'd1);

    // 2: byte order and go-to-valid latency
    rand_ready = 1'b0;
    ready_fixed = 1'b1;
    flush = 1'b1;
    cap_q.delete();
    push_word(32'h4433_2211);
    lat = 0;
    while (!tx_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("t2_latency", 32'(lat), 32'd3);
    drain("t2");
    chk("t2_ncap", 32'(cap_q.size()), 32'd4);
    if (cap_q.size() == 4) begin
      chk("t2_b0", 32'(cap_q[0]), 32'h11);
      chk("t2_b1", 32'(cap_q[1]), 32'h22);
      chk("t2_b2", 32'(cap_q[2]), 32'h33);
      chk("t2_b3", 32'(cap_q[3]), 32'h44);
    end

    // 3: backpressure on byte 2
    push_word(32'hA1B2_C3D4);
    n = 0;
    while (acc % 4 != 2 && n < 100) begin
      step();
      n++;
    end
    ready_fixed = 1'b0;
    p0 = pops;
    repeat (10) step();
    chk("t3_valid", 32'(tx_valid), 32'd1);
    chk("t3_data", 32'(tx_data), 32'hB2);
    chk("t3_no_pop", 32'(pops - p0), 32'd0);
    ready_fixed = 1'b1;
    drain("t3");
    flush = 1'b0;

    // 4: full wrap, burst started only by fifo_full
    fifo_rdy = 1'b0;
    a0 = acc;
    p0 = pops;
    for (int i = 0; i < 256; i++) push_word($urandom);
    repeat (4) step();
    chk("t4_held", 32'(busy), 32'd0);
    fifo_rdy = 1'b1;
    rand_ready = 1'b1;
    drain("t4");
    chk("t4_bytes", 32'(acc - a0), 32'd1024);
    chk("t4_pops", 32'(pops - p0), 32'd256);
    chk("t4_empty", 32'(fifo_empty), 32'd1);

    // 5: reset while byte 1 is presented
    rand_ready = 1'b0;
    ready_fixed = 1'b1;
    flush = 1'b1;
    for (int i = 0; i < 4; i++) push_word($urandom);
    n = 0;
    while (acc % 4 != 1 && n < 100) begin
      step();
      n++;
    end
    ready_fixed = 1'b0;
    step();
    nrst = 1'b0;
    #1;
    chk("t5_valid", 32'(tx_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("t5_data", 32'(tx_data), 32'd0);
    chk("t5_cnt", 32'(word_cnt), 32'd0);
    for (int i = acc % 4; i < 4; i++) void'(exp_q.pop_front());
    acc = 0;
    prev_stall = 1'b0;
    ready_fixed = 1'b1;
    step();
    nrst = 1'b1;
    drain("t5");
    chk("t5_words", 32'(word_cnt), 32'd3);

    // 6: ready gating, then counter wrap at 17 words
    fifo_rdy = 1'b0;
    p0 = pops;
    for (int i = 0; i < 14; i++) push_word($urandom);
    repeat (20) step();
    chk("t6_no_pop", 32'(pops - p0), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    fifo_rdy = 1'b1;
    rand_ready = 1'b1;
    drain("t6");
    chk("t6_wrap", 32'(word_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
